// File: rtl/roi_pixel_cropper.sv
// roi_pixel_cropper: forwards the in-window pixels of one requested frame with sof/eol/eof markers
module roi_pixel_cropper #(
   parameter int IMG_WIDTH  = 1280,
   parameter int IMG_HEIGHT = 720,
   parameter int DATA_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              win_load,
   input  logic [11:0]       win_x_start,
   input  logic [11:0]       win_x_end,
   input  logic [11:0]       win_y_start,
   input  logic [11:0]       win_y_end,
   input  logic              crop_req,
   input  logic              in_vsync,
   input  logic              in_de,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sof,
   output logic              out_eol,
   output logic              out_eof,
   output logic              busy,
   output logic              done,
   output logic              err
);
   typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;
   localparam logic [11:0] W  = 12'(IMG_WIDTH);
   localparam logic [11:0] H1 = 12'(IMG_HEIGHT - 1);
   state_t state, state_nxt;
   logic [11:0] pend_xs, pend_xe, pend_ys, pend_ye;
   logic [11:0] act_xs, act_xe, act_ys, act_ye;
   logic [11:0] sel_xs, sel_xe, sel_ys, sel_ye;
   logic [11:0] x_cnt, y_cnt, x_nxt, y_nxt;
   logic        bad, pix, last, in_win, start, err_nxt;
   always_comb begin
      sel_xs    = win_load ? win_x_start : pend_xs;
      sel_xe    = win_load ? win_x_end   : pend_xe;
      sel_ys    = win_load ? win_y_start : pend_ys;
      sel_ye    = win_load ? win_y_end   : pend_ye;
      bad       = sel_xs == 12'd0 || sel_xs > sel_xe || sel_xe > W || sel_ys > sel_ye || sel_ye > H1;
      pix       = state == ACTIVE && in_de && !in_vsync;
      x_nxt     = (x_cnt == W) ? 12'd1 : x_cnt + 12'd1;
      y_nxt     = (x_cnt == W) ? y_cnt + 12'd1 : y_cnt;
      last      = pix && x_nxt == W && y_nxt == H1;
      in_win    = pix && x_nxt >= act_xs && x_nxt <= act_xe && y_nxt >= act_ys && y_nxt <= act_ye;
      start     = state == ARMED && in_vsync && !bad;
      err_nxt   = in_vsync && ((state == ARMED && bad) || state == ACTIVE);
      state_nxt = (state == IDLE && crop_req) ? ARMED :
                  start                       ? ACTIVE :
                  (err_nxt || last)           ? IDLE : state;
   end
   assign busy = state != IDLE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pend_xs   <= 12'd1;
         pend_xe   <= 12'd300;
         pend_ys   <= 12'd0;
         pend_ye   <= 12'd149;
         act_xs    <= '0;
         act_xe    <= '0;
         act_ys    <= '0;
         act_ye    <= '0;
         x_cnt     <= '0;
         y_cnt     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state <= state_nxt;
         if (win_load) begin
            pend_xs <= win_x_start;
            pend_xe <= win_x_end;
            pend_ys <= win_y_start;
            pend_ye <= win_y_end;
         end
         if (start) begin
            act_xs <= sel_xs;
            act_xe <= sel_xe;
            act_ys <= sel_ys;
            act_ye <= sel_ye;
            x_cnt  <= '0;
            y_cnt  <= '0;
         end else if (pix) begin
            x_cnt <= x_nxt;
            y_cnt <= y_nxt;
         end
         out_valid <= in_win;
         out_data  <= in_win ? in_data : out_data;
         out_sof   <= in_win && x_nxt == act_xs && y_nxt == act_ys;
         out_eol   <= in_win && x_nxt == act_xe;
         out_eof   <= in_win && x_nxt == act_xe && y_nxt == act_ye;
         done      <= last;
         err       <= err_nxt;
      end
   end
endmodule

// File: tb/tb_roi_pixel_cropper.sv
// tb_roi_pixel_cropper: directed frames on a reduced 40x12 image, scoreboard of expected cropped pixels
module tb_roi_pixel_cropper;
   localparam int W = 40;
   localparam int H = 12;
   logic clk = 0, rst_n = 0, win_load = 0, crop_req = 0, in_vsync = 0, in_de = 0;
   logic [11:0] win_x_start = 0, win_x_end = 0, win_y_start = 0, win_y_end = 0;
   logic [7:0] in_data = 0, out_data;
   logic out_valid, out_sof, out_eol, out_eof, busy, done, err;
   int checks = 0, errors = 0;
   int n_valid = 0, n_sof = 0, n_eol = 0, n_eof = 0, n_done = 0, n_err = 0;
   int v0, s0, l0, f0, d0, e0;
   logic [10:0] sb[$];

   always #5 clk = ~clk;

   roi_pixel_cropper #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .win_load(win_load),
      .win_x_start(win_x_start), .win_x_end(win_x_end),
      .win_y_start(win_y_start), .win_y_end(win_y_end),
      .crop_req(crop_req), .in_vsync(in_vsync), .in_de(in_de), .in_data(in_data),
      .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
      .out_eof(out_eof), .busy(busy), .done(done), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      in_de = 0; in_vsync = 0; crop_req = 0; win_load = 0;
   endtask

   task automatic set_win(input logic [11:0] xs, xe, ys, ye);
      win_x_start = xs; win_x_end = xe; win_y_start = ys; win_y_end = ye;
   endtask

   task automatic snap();
      v0 = n_valid; s0 = n_sof; l0 = n_eol; f0 = n_eof; d0 = n_done; e0 = n_err;
   endtask

   task automatic chk_counts(input string t, input int v, s, l, f, d, e);
      chk({t, "_valid"}, 32'(n_valid - v0), 32'(v));
      chk({t, "_sof"}, 32'(n_sof - s0), 32'(s));
      chk({t, "_eol"}, 32'(n_eol - l0), 32'(l));
      chk({t, "_eof"}, 32'(n_eof - f0), 32'(f));
      chk({t, "_done"}, 32'(n_done - d0), 32'(d));
      chk({t, "_err"}, 32'(n_err - e0), 32'(e));
      chk({t, "_sb_empty"}, 32'(sb.size()), 0);
   endtask

   task automatic pixel(input int x, y, input bit cap, input logic [11:0] xs, xe, ys, ye);
      logic [7:0] d;
      d = 8'(x + 3 * y);
      tick();
      in_de = 1;
      in_data = d;
      if (cap && x >= int'(xs) && x <= int'(xe) && y >= int'(ys) && y <= int'(ye))
         sb.push_back({x == int'(xs) && y == int'(ys), x == int'(xe), x == int'(xe) && y == int'(ye), d});
   endtask

   task automatic send_frame(input int lines, input bit gaps, input bit cap, input bit vs_load,
                             input logic [11:0] xs, xe, ys, ye, input int ld_line);
      tick();
      in_vsync = 1;
      win_load = vs_load;
      for (int y = 0; y < lines; y++)
         for (int x = 1; x <= W; x++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            pixel(x, y, cap, xs, xe, ys, ye);
            if (y == ld_line && x == 1) win_load = 1;
         end
   endtask

   always @(negedge clk) begin
      if (out_valid) begin
         n_valid++;
         if (out_sof) n_sof++;
         if (out_eol) n_eol++;
         if (out_eof) n_eof++;
         if (sb.size() == 0) chk("sb_depth_on_output", 0, 1);
         else chk("out_pixel", 32'({out_sof, out_eol, out_eof, out_data}), 32'(sb.pop_front()));
      end else chk("markers_idle", 32'({out_sof, out_eol, out_eof}), 0);
      if (done) n_done++;
      if (err) n_err++;
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_outputs", 32'({out_valid, out_sof, out_eol, out_eof, busy, done, err, out_data}), 0);
      rst_n = 1;
      // reset pending window (x_end 300) is illegal for a 40-pixel line
      snap();
      tick(); crop_req = 1;
      tick(); chk("busy_rise", 32'(busy), 1);
      in_vsync = 1;
      tick(); chk("default_win_err", 32'(err), 1); chk("default_win_busy", 32'(busy), 0);
      tick(); chk("err_pulse", 32'(err), 0);
      chk_counts("default", 0, 0, 0, 0, 0, 1);
      tick(); set_win(5, 12, 2, 6); win_load = 1;
      snap();
      tick(); crop_req = 1;
      send_frame(H, 0, 1, 0, 5, 12, 2, 6, -1);
      tick(); chk("A_done", 32'(done), 1); chk("A_busy_fall", 32'(busy), 0);
      tick(); chk("A_done_pulse", 32'(done), 0);
      chk_counts("A", 40, 1, 5, 1, 1, 0);
      snap();
      send_frame(2, 0, 0, 0, 5, 12, 2, 6, -1);
      tick(); tick();
      chk_counts("idle_ignored", 0, 0, 0, 0, 0, 0);
      tick(); set_win(31, 40, 9, 11); win_load = 1;
      tick(); crop_req = 1; in_vsync = 1;
      send_frame(H, 0, 1, 0, 31, 40, 9, 11, -1);
      tick(); chk("B_done_eof", 32'({done, out_eof, out_valid}), 32'h7);
      tick();
      chk_counts("B", 30, 1, 3, 1, 1, 0);
      tick(); set_win(5, 12, 2, 6); win_load = 1;
      tick(); set_win(31, 40, 9, 11);
      snap(); crop_req = 1;
      send_frame(H, 0, 1, 0, 5, 12, 2, 6, 3);
      tick(); tick();
      chk_counts("frozen", 40, 1, 5, 1, 1, 0);
      snap();
      tick(); crop_req = 1;
      send_frame(H, 0, 1, 0, 31, 40, 9, 11, -1);
      tick(); tick();
      chk_counts("reloaded", 30, 1, 3, 1, 1, 0);
      tick(); set_win(30, 20, 0, 5); win_load = 1;
      snap();
      tick(); crop_req = 1;
      tick(); in_vsync = 1;
      tick(); chk("bad_err", 32'(err), 1); chk("bad_busy", 32'(busy), 0);
      send_frame(2, 0, 0, 0, 30, 20, 0, 5, -1);
      tick(); tick();
      chk_counts("bad", 0, 0, 0, 0, 0, 1);
      snap();
      tick(); crop_req = 1; set_win(1, 3, 0, 0);
      send_frame(H, 0, 1, 1, 1, 3, 0, 0, -1);
      tick(); tick();
      chk_counts("bypass", 3, 1, 1, 1, 1, 0);
      snap();
      tick(); crop_req = 1;
      send_frame(5, 0, 1, 0, 1, 3, 0, 0, -1);
      tick(); in_vsync = 1;
      tick(); chk("short_err", 32'({err, done, busy}), 32'h4);
      tick(); tick();
      chk_counts("short", 3, 1, 1, 1, 0, 1);
      snap();
      tick(); crop_req = 1;
      send_frame(H, 1, 1, 0, 1, 3, 0, 0, -1);
      tick(); chk("after_short_done", 32'(done), 1);
      tick();
      chk_counts("after_short", 3, 1, 1, 1, 1, 0);
      // abort at pixel (8,3), inside window A
      tick(); set_win(5, 12, 2, 6); win_load = 1;
      snap();
      tick(); crop_req = 1;
      send_frame(3, 0, 1, 0, 5, 12, 2, 6, -1);
      for (int x = 1; x <= 8; x++) pixel(x, 3, 1, 5, 12, 2, 6);
      tick();
      #1 rst_n = 0;
      #1 chk("abort_outputs", 32'({out_valid, out_sof, out_eol, out_eof, busy, done, err, out_data}), 0);
      repeat (3) tick();
      rst_n = 1;
      repeat (3) tick();
      chk_counts("abort", 12, 1, 1, 0, 0, 0);
      tick(); set_win(5, 12, 2, 6); win_load = 1;
      snap();
      tick(); crop_req = 1;
      send_frame(H, 1, 1, 0, 5, 12, 2, 6, -1);
      tick(); chk("gaps_done", 32'(done), 1);
      tick();
      chk_counts("gaps", 40, 1, 5, 1, 1, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
